demux1x2_stream: RTL and testbench
==================================

// Module: demux1x2_stream
// PURPOSE
//  1-to-2 stream demultiplexer: the distribution-side counterpart of the 2:1 mux datapath.
//  Each accepted input word is steered to out0 (select=0) or out1 (select=1).
//  The word is held in a one-entry register slot per output, under valid/ready handshakes.
//  Sits between a single producer and two independent consumers.
//  Keeps a wrapping per-output delivery count.
// PARAMETERS
//  WIDTH   8  data word width in bits
//  CNT_W   8  width of each per-output delivery counter
// PORTS
//  clk         in   1      single clock; all state updates on rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  in_data     in   WIDTH  input word
//  in_valid    in   1      input word present
//  in_ready    out  1      block can accept in_data this cycle
//  select      in   1      destination: 0 -> out0, 1 -> out1; sampled only on accept
//  out0_data   out  WIDTH  slot 0 word
//  out0_valid  out  1      slot 0 full
//  out0_ready  in   1      consumer 0 takes out0_data
//  out1_data   out  WIDTH  slot 1 word
//  out1_valid  out  1      slot 1 full
//  out1_ready  in   1      consumer 1 takes out1_data
//  cnt0        out  CNT_W  number of out0 transfers, mod 2^CNT_W
//  cnt1        out  CNT_W  number of out1 transfers, mod 2^CNT_W
// BEHAVIOUR
//  - Reset (rst_n=0, async): outX_valid=0, outX_data=0, cnt0=cnt1=0.
//    Reset mid-operation discards held words immediately.
//  - Per-slot FSM, X in {0,1}: EMPTY (outX_valid=0) / FULL (outX_valid=1).
//  - Accept: acc = in_valid & in_ready.
//    in_ready = ~outX_valid | outX_ready, where X = select. Combinational.
//    in_ready follows select even when in_valid=0.
//  - Output transfer: doneX = outX_valid & outX_ready.
//  - Slot X next state:
//      acc to X                    -> FULL, outX_data <= in_data
//                                     (overwrite legal only because doneX is also true)
//      doneX and no acc to X       -> EMPTY; outX_data keeps its last value
//      otherwise                   -> hold
//  - Latency: a word accepted at edge N is on outX_data with outX_valid=1 after edge N.
//  - Throughput: one word per cycle into a slot when its consumer holds ready=1.
//  - Independence: slots are independent.
//    Same cycle: out0 may drain while out1 loads, and both outputs may drain.
//    A stalled out1 never blocks traffic with select=0.
//  - FULL slot: outX_data and outX_valid stay stable until doneX (no retraction, no change).
//  - Counters: cntX <= cntX + 1 on doneX. Wraps 2^CNT_W-1 -> 0. No saturation.
//  - No combinational path from in_data to outX_data.
//    The only combinational path is outX_ready/select -> in_ready.
// TESTING
//  T1 reset: rst_n=0 asynchronously mid-cycle -> outX_valid=0, cnt=0 without a clock edge;
//     after release in_ready=1.
//  T2 route: in_data=8'hA5 sel=0, then 8'h3C sel=1, both readies=1
//     -> out0 shows A5, then out1 shows 3C, each one cycle after accept;
//     cnt0=1, cnt1=1.
//  T3 backpressure: out1_ready=0, send 8'h11 sel=1 and then hold sel=1
//     -> in_ready=0, out1_data=11 stable for 5 cycles;
//     switch sel=0 -> in_ready=1 and 8'h22 reaches out0.
//  T4 streaming: out0_ready=1, 6 back-to-back words sel=0 (01..06)
//     -> in_ready stays 1, words appear in order with no bubbles, cnt0=6.
//  T5 simultaneous: slot0 FULL, out0_ready=1 and new accept sel=0 in the same cycle
//     -> no gap (out0_valid stays 1), new word replaces old, cnt0 +1.
//  T6 wrap: CNT_W=8, 256 transfers to out1 -> cnt1 = 0; 257th -> cnt1 = 1.

Source files
------------

// File: rtl/demux1x2_stream.sv
// 1-to-2 stream demultiplexer: each accepted word is steered by select into one of two
// independent one-entry output slots, each with its own wrapping delivery counter.

module demux1x2_stream_slot #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic [CNT_W-1:0] cnt
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t state;
    logic   done;

    assign done = valid & ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            valid <= 1'b0;
            data  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (load) begin
                        state <= FULL;
                        valid <= 1'b1;
                        data  <= load_data;
                    end
                end
                FULL: begin
                    // load into a FULL slot only happens while it drains, so no gap
                    if (load) begin
                        data <= load_data;
                    end else if (ready) begin
                        state <= EMPTY;
                        valid <= 1'b0;
                    end
                end
                default: begin
                    state <= EMPTY;
                    valid <= 1'b0;
                end
            endcase
            if (done)
                cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

module demux1x2_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             select,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);
    localparam int NUM_SLOTS = 2;

    logic [NUM_SLOTS-1:0][WIDTH-1:0] slot_data;
    logic [NUM_SLOTS-1:0][CNT_W-1:0] slot_cnt;
    logic [NUM_SLOTS-1:0]            slot_valid;
    logic [NUM_SLOTS-1:0]            slot_ready;
    logic [NUM_SLOTS-1:0]            slot_load;
    logic                            acc;

    assign slot_ready = {out1_ready, out0_ready};

    // only the selected slot gates acceptance; the other slot's stall is irrelevant
    assign in_ready = ~slot_valid[select] | slot_ready[select];
    assign acc      = in_valid & in_ready;

    genvar i;
    generate
        for (i = 0; i < NUM_SLOTS; i++) begin : g_slot
            assign slot_load[i] = acc & (select == 1'(i));

            demux1x2_stream_slot #(
                .WIDTH (WIDTH),
                .CNT_W (CNT_W)
            ) u_slot (
                .clk       (clk),
                .rst_n     (rst_n),
                .load      (slot_load[i]),
                .load_data (in_data),
                .ready     (slot_ready[i]),
                .data      (slot_data[i]),
                .valid     (slot_valid[i]),
                .cnt       (slot_cnt[i])
            );
        end
    endgenerate

    assign out0_data  = slot_data[0];
    assign out0_valid = slot_valid[0];
    assign cnt0       = slot_cnt[0];
    assign out1_data  = slot_data[1];
    assign out1_valid = slot_valid[1];
    assign cnt1       = slot_cnt[1];
endmodule

// File: tb/tb_demux1x2_stream.sv
// Directed bench for demux1x2_stream: reset, routing, backpressure, streaming,
// simultaneous drain/load and counter wrap, all against hand-computed values.

module tb_demux1x2_stream;
    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             select = 1'b0;
    logic [WIDTH-1:0] out0_data, out1_data;
    logic             out0_valid, out1_valid;
    logic             out0_ready = 1'b0, out1_ready = 1'b0;
    logic [CNT_W-1:0] cnt0, cnt1;

    int n_total = 0;
    int n_bad   = 0;

    demux1x2_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .select     (select),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // inputs change at negedge; one tick crosses exactly one rising edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [WIDTH-1:0] d, input logic s, input logic v);
        in_data  = d;
        select   = s;
        in_valid = v;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        // T1: power-on reset
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_v0", 32'(out0_valid), 32'h0);
        chk("rst_v1", 32'(out1_valid), 32'h0);
        chk("rst_d0", 32'(out0_data), 32'h0);
        chk("rst_cnt0", 32'(cnt0), 32'h0);
        chk("rst_cnt1", 32'(cnt1), 32'h0);
        @(negedge clk);

        // T2: route one word to each output
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        drive(8'hA5, 1'b0, 1'b1);
        tick();
        chk("t2_v0", 32'(out0_valid), 32'h1);
        chk("t2_d0", 32'(out0_data), 32'hA5);
        chk("t2_v1_idle", 32'(out1_valid), 32'h0);
        drive(8'h3C, 1'b1, 1'b1);
        tick();
        chk("t2_v1", 32'(out1_valid), 32'h1);
        chk("t2_d1", 32'(out1_data), 32'h3C);
        chk("t2_v0_drained", 32'(out0_valid), 32'h0);
        chk("t2_cnt0", 32'(cnt0), 32'h1);
        drive(8'h00, 1'b1, 1'b0);
        tick();
        chk("t2_v1_drained", 32'(out1_valid), 32'h0);
        chk("t2_cnt1", 32'(cnt1), 32'h1);
        chk("t2_d1_kept", 32'(out1_data), 32'h3C);

        // T1b: asynchronous reset mid-operation drops a held word without a clock edge
        out1_ready = 1'b0;
        drive(8'h55, 1'b1, 1'b1);
        tick();
        drive(8'h00, 1'b1, 1'b0);
        chk("t1b_held", 32'(out1_valid), 32'h1);
        rst_n = 1'b0;
        #2;
        chk("t1b_v1", 32'(out1_valid), 32'h0);
        chk("t1b_d1", 32'(out1_data), 32'h0);
        chk("t1b_cnt0", 32'(cnt0), 32'h0);
        chk("t1b_cnt1", 32'(cnt1), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t1b_in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);

        // T3: out1 stalled, select=0 traffic still flows
        out0_ready = 1'b1;
        out1_ready = 1'b0;
        drive(8'h11, 1'b1, 1'b1);
        tick();
        drive(8'h99, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t3_in_ready", 32'(in_ready), 32'h0);
            chk("t3_d1", 32'(out1_data), 32'h11);
            chk("t3_v1", 32'(out1_valid), 32'h1);
            tick();
        end
        drive(8'h22, 1'b0, 1'b1);
        #1;
        chk("t3_sel0_ready", 32'(in_ready), 32'h1);
        tick();
        chk("t3_v0", 32'(out0_valid), 32'h1);
        chk("t3_d0", 32'(out0_data), 32'h22);
        chk("t3_d1_still", 32'(out1_data), 32'h11);
        drive(8'h00, 1'b0, 1'b0);
        tick();
        chk("t3_cnt0", 32'(cnt0), 32'h1);
        chk("t3_cnt1", 32'(cnt1), 32'h0);

        // T4: back-to-back streaming into out0
        pulse_reset();
        out0_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            drive(WIDTH'(k), 1'b0, 1'b1);
            #1;
            chk("t4_in_ready", 32'(in_ready), 32'h1);
            tick();
            chk("t4_v0", 32'(out0_valid), 32'h1);
            chk("t4_d0", 32'(out0_data), 32'(k));
        end
        drive(8'h00, 1'b0, 1'b0);
        tick();
        chk("t4_v0_end", 32'(out0_valid), 32'h0);
        chk("t4_cnt0", 32'(cnt0), 32'h6);

        // T5: drain and reload slot 0 in the same cycle
        out0_ready = 1'b0;
        drive(8'h77, 1'b0, 1'b1);
        tick();
        chk("t5_d0_first", 32'(out0_data), 32'h77);
        chk("t5_stalled", 32'(in_ready), 32'h0);
        out0_ready = 1'b1;
        drive(8'h88, 1'b0, 1'b1);
        #1;
        chk("t5_ready", 32'(in_ready), 32'h1);
        tick();
        chk("t5_v0", 32'(out0_valid), 32'h1);
        chk("t5_d0", 32'(out0_data), 32'h88);
        chk("t5_cnt0", 32'(cnt0), 32'h7);
        drive(8'h00, 1'b0, 1'b0);
        tick();
        chk("t5_cnt0_end", 32'(cnt0), 32'h8);
        chk("t5_v0_end", 32'(out0_valid), 32'h0);

        // T6: counter wrap on out1
        pulse_reset();
        out1_ready = 1'b1;
        for (int k = 0; k < 256; k++) begin
            drive(WIDTH'(k), 1'b1, 1'b1);
            tick();
        end
        chk("t6_cnt1_255", 32'(cnt1), 32'hFF);
        drive(8'h00, 1'b1, 1'b0);
        tick();
        chk("t6_cnt1_wrap", 32'(cnt1), 32'h0);
        chk("t6_d1_last", 32'(out1_data), 32'hFF);
        drive(8'h5A, 1'b1, 1'b1);
        tick();
        drive(8'h00, 1'b1, 1'b0);
        tick();
        chk("t6_cnt1_257", 32'(cnt1), 32'h1);
        chk("t6_cnt0", 32'(cnt0), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
